// File: rtl/btb_pkg.sv
// btb_pkg -- shared types and constants for the set-associative branch target buffer.
//   btb_entry_t  : one BTB way (valid, tag, target, direction counter)
//   PC_INCR      : fall-through increment used on a miss
//   weakly_taken : counter initial value for a freshly allocated entry
// Tag and counter fields are sized for the largest legal configuration;
// narrower configurations keep the unused upper bits at zero.
package btb_pkg;

    localparam int unsigned TAG_MAX_W = 30;
    localparam int unsigned CTR_MAX_W = 4;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [CTR_MAX_W-1:0] counter;
    } btb_entry_t;

    // MSB of a bits-wide counter set, all lower bits clear.
    function automatic logic [CTR_MAX_W-1:0] weakly_taken(input int unsigned bits);
        logic [CTR_MAX_W-1:0] r;
        r = '0;
        r[bits-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- next-state logic of a saturating up/down counter.
//   cnt_in  : current counter value
//   up      : 1 = increment, 0 = decrement
//   cnt_out : next value, held at 0 / all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cnt_in,
    input  logic         up,
    output logic [W-1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (up) begin
            if (cnt_in != '1) cnt_out = cnt_in + W'(1);
        end else begin
            if (cnt_in != '0) cnt_out = cnt_in - W'(1);
        end
    end

endmodule

// File: rtl/branch_target_buffer_assoc.sv
// branch_target_buffer_assoc -- set-associative BTB with per-entry direction
// counters and tree pseudo-LRU replacement.
//   clk, clear_n            : clock, synchronous active-low reset
//   pc                      : lookup address (combinational lookup)
//   target, pred, hit       : predicted target, taken prediction, tag hit
//   update_en/_outcome      : resolve strobe and taken flag
//   update_pc/_target       : resolved branch address and target
// Optional feature macro BTB_STATS_EN adds stat_updates / stat_mispredicts.
module branch_target_buffer_assoc
    import btb_pkg::*;
#(
    parameter int unsigned SETS     = 16,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic [31:0] pc,
    input  logic        update_en,
    input  logic        update_outcome,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    output logic [31:0] target,
    output logic        pred,
`ifdef BTB_STATS_EN
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts,
`endif
    output logic        hit
);

    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    btb_entry_t        entries [SETS][WAYS];
    logic [PLRU_W-1:0] plru    [SETS];

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] a);
        return TAG_MAX_W'(a >> (2 + IDX_W));
    endfunction

    // Tree bit = 1 means the victim lies on the upper-numbered side.
    // Bit 0 is the root; for 4 ways bits 1/2 choose within ways 0-1 / 2-3.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                     input logic [WAY_W-1:0]  w);
        logic [2:0] t;
        logic [1:0] w2;
        t  = 3'(b);
        w2 = 2'(w);
        if (WAYS == 2) begin
            t[0] = ~w2[0];
        end else if (WAYS == 4) begin
            t[0] = ~w2[1];
            if (!w2[1]) t[1] = ~w2[0];
            else        t[2] = ~w2[0];
        end
        return PLRU_W'(t);
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] b);
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(b);
        v = '0;
        if (WAYS == 2)      v = {1'b0, t[0]};
        else if (WAYS == 4) v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
        return WAY_W'(v);
    endfunction

    // Lookup port: reads registered state only, so same-cycle updates are not bypassed.
    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;

    always_comb begin
        lk_idx = pc[2 +: IDX_W];
        lk_hit = 1'b0;
        lk_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (entries[lk_idx][w].valid && entries[lk_idx][w].tag == tag_of(pc)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    assign hit    = lk_hit;
    assign target = lk_hit ? entries[lk_idx][lk_way].target : pc + PC_INCR;
    assign pred   = lk_hit & entries[lk_idx][lk_way].counter[CTR_BITS-1];

    // Update port.
    logic [IDX_W-1:0]    up_idx;
    logic                up_hit;
    logic [WAY_W-1:0]    up_way;
    logic [WAY_W-1:0]    alloc_way;
    logic                found_inv;
    logic [WAY_W-1:0]    touch_way;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_next;
    logic                up_pred;

    always_comb begin
        up_idx    = update_pc[2 +: IDX_W];
        up_hit    = 1'b0;
        up_way    = '0;
        alloc_way = plru_victim(plru[up_idx]);
        found_inv = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (entries[up_idx][w].valid && entries[up_idx][w].tag == tag_of(update_pc)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!found_inv && !entries[up_idx][w].valid) begin
                alloc_way = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
        touch_way = up_hit ? up_way : alloc_way;
        ctr_cur   = up_hit ? entries[up_idx][up_way].counter[CTR_BITS-1:0] : '0;
        up_pred   = up_hit & ctr_cur[CTR_BITS-1];
    end

    sat_counter #(.W(CTR_BITS)) u_ctr (
        .cnt_in  (ctr_cur),
        .up      (update_outcome),
        .cnt_out (ctr_next)
    );

    // Address LSBs never participate in indexing or tagging.
    logic unused_lsbs;
    assign unused_lsbs = ^update_pc[1:0];

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                plru[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) entries[s][w] <= '0;
            end
        end else if (update_en) begin
            if (up_hit) begin
                entries[up_idx][up_way].counter <= CTR_MAX_W'(ctr_next);
                if (update_outcome) entries[up_idx][up_way].target <= update_target;
                plru[up_idx] <= plru_touch(plru[up_idx], touch_way);
            end else if (update_outcome) begin
                entries[up_idx][alloc_way] <= '{valid:   1'b1,
                                               tag:     tag_of(update_pc),
                                               target:  update_target,
                                               counter: weakly_taken(CTR_BITS)};
                plru[up_idx] <= plru_touch(plru[up_idx], touch_way);
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (update_en) begin
            if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
            if (up_pred != update_outcome && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_target_buffer_assoc.md
BRANCH_TARGET_BUFFER_ASSOC -- requirements
Module: branch_target_buffer_assoc

Interface
REQ-001 SHALL have parameter SETS, default 16, number of sets (power of two, 2..256).
REQ-002 SHALL have parameter WAYS, default 2, associativity (1, 2 or 4 only).
REQ-003 SHALL have parameter CTR_BITS, default 2, width of the per-entry direction counter (2..4).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port clear_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pc  input  32  lookup address.
REQ-007 SHALL have ports update_en (input, 1) and update_outcome (input, 1): resolve strobe and taken flag.
REQ-008 SHALL have ports update_pc (input, 32) and update_target (input, 32): resolved branch address and target.
REQ-009 SHALL have ports target (output, 32), pred (output, 1) and hit (output, 1): predicted target, taken prediction and tag-hit flag.

Function
REQ-010 SHALL take index = pc[2 +: log2(SETS)] and tag = pc[31 : 2+log2(SETS)]; pc[1:0] SHALL be ignored.
REQ-011 Lookup SHALL be combinational from registered state: hit = any valid way with matching tag.
REQ-012 On hit, target SHALL be the stored target and pred SHALL be the counter MSB; on miss, target = pc + 4 (mod 2^32) and pred = 0.
REQ-013 No way SHALL ever hold two valid entries with the same tag in one set.
REQ-014 update_en high with update_pc hitting: counter SHALL saturate-increment if taken, else saturate-decrement; target SHALL be overwritten only when taken.
REQ-015 update_en high, miss, taken: SHALL allocate the lowest-numbered invalid way, else the pseudo-LRU victim; counter SHALL initialise to weakly-taken (MSB=1, other bits 0).
REQ-016 update_en high, miss, not taken: SHALL leave the entries and replacement state unchanged.
REQ-017 Pseudo-LRU: WAYS-1 tree bits per set (none for WAYS=1); updated to mark the touched way most-recent on update hit or allocation only, never on lookup.
REQ-018 Lookup and update of the same PC in one cycle SHALL return pre-update state (no bypass); the update becomes visible next cycle.
REQ-019 Counters SHALL saturate at 0 and 2^CTR_BITS-1, never wrap.

Reset
REQ-020 clear_n low at a rising edge SHALL clear all valid bits, counters and pseudo-LRU bits; an update asserted in that cycle SHALL be discarded.
REQ-021 After reset every lookup SHALL return hit=0, pred=0, target=pc+4.

Configuration
REQ-022 With BTB_STATS_EN defined, SHALL add outputs stat_updates (32) and stat_mispredicts (32), incremented per update_en cycle and per update whose pre-update prediction (miss counts as not-taken) differs from update_outcome; both saturate at 2^32-1 and clear on reset.
REQ-023 Without BTB_STATS_EN, these ports and counters SHALL NOT exist.

Structure
REQ-024 Package btb_pkg SHALL hold btb_entry_t (valid, tag, target, counter), the weakly-taken constant function and the PC+4 constant.
REQ-025 The saturating direction counter SHALL be sub-module sat_counter, instantiated per entry or as shared next-state logic.

Verification (SETS=16, WAYS=2, CTR_BITS=2)
REQ-026 Reset, then lookup pc=0x40 -> hit=0, pred=0, target=0x44.
REQ-027 Update 0x40 taken, target 0x100; next cycle lookup 0x40 -> hit=1, pred=1, target=0x100; two not-taken updates -> hit=1, pred=0, target=0x100.
REQ-028 Three taken updates to 0x40 -> counter 11 (stays 11 on a fourth); then one not-taken -> pred=1.
REQ-029 Allocate 0x40, then 0x80 (both set 0); taken update to 0x40; allocate 0xC0 -> 0x80 misses (target 0x84), 0x40 and 0xC0 hit.
REQ-030 Assert clear_n=0 with update_en=1 for 0x200 -> next cycle lookups of 0x40 and 0x200 both miss.
REQ-031 With BTB_STATS_EN: from reset, update 0x40 taken twice -> stat_updates=2, stat_mispredicts=1.
